// File: rtl/conv_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// conv_arbiter_pkg
// Shared constants for the convolution arbiter slice: default geometry of the
// requester array, datapath widths, result buffer depth and the derived
// requester-id width used for tags and res_id.
// ---------------------------------------------------------------------------
package conv_arbiter_pkg;

    // A convolution window is always 3x3.
    localparam int TAPS           = 9;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ACC_W      = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    // Width of a requester index.
    // It is never narrower than one bit, so a single-requester build still has a legal id port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ID_W       = id_width(DEF_N_REQ);

endpackage

// File: rtl/conv_core.sv
// ---------------------------------------------------------------------------
// conv_core
// Single-cycle 3x3 convolution engine: registers the signed sum of nine
// DATA_W x DATA_W signed products, sign-extended to ACC_W.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   valid_in   window/weight are valid this cycle
//   window     nine packed signed pixels, tap k at [k*DATA_W +: DATA_W]
//   weight     nine packed signed weights, same layout
//   valid_out  result holds the sum for the previous cycle's valid_in
//   result     signed convolution sum
// ---------------------------------------------------------------------------
module conv_core
    import conv_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic [TAPS*DATA_W-1:0]   window,
    input  logic [TAPS*DATA_W-1:0]   weight,
    output logic                     valid_out,
    output logic [ACC_W-1:0]         result
);

    logic [2*DATA_W-1:0] px_ext;
    logic [2*DATA_W-1:0] wt_ext;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    sum;

    // Multiply-accumulate over the nine taps.
    // Both operands are sign-extended to double width first.
    // The low 2*DATA_W bits of that unsigned product are then the exact signed product.
    always_comb begin
        px_ext = '0;
        wt_ext = '0;
        prod   = '0;
        sum    = '0;
        for (int k = 0; k < TAPS; k++) begin
            px_ext = {{DATA_W{window[k*DATA_W+DATA_W-1]}}, window[k*DATA_W +: DATA_W]};
            wt_ext = {{DATA_W{weight[k*DATA_W+DATA_W-1]}}, weight[k*DATA_W +: DATA_W]};
            prod   = px_ext * wt_ext;
            sum    = sum + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    end

    // Output register: this is the core's one cycle of latency.
    // result only moves when a new operation arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            result    <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                result <= sum;
            end
        end
    end

endmodule

// File: rtl/conv_arbiter.sv
// ---------------------------------------------------------------------------
// conv_arbiter
// Shares one conv_core among N_REQ requesters using round-robin arbitration.
// Results are buffered in an in-order FIFO tagged with the requester index.
// Issue is credit-limited: operations in flight plus buffered results never
// exceed FIFO_DEPTH, so the FIFO cannot overflow.
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   req_valid    per-requester request valid
//   req_window   per-requester 3x3 window, requester i at slice i
//   req_weight   per-requester 3x3 kernel, same slicing
//   req_ready    one-hot (or zero) accept, combinational
//   res_valid    FIFO head holds a result
//   res_ready    downstream accepts the head result
//   res_data     signed convolution sum at the head
//   res_id       requester index of the head result
//   busy         an operation is in the core or a result is buffered
//   res_count    count of popped results, wraps at 16 bits
// ---------------------------------------------------------------------------
module conv_arbiter
    import conv_arbiter_pkg::*;
#(
    parameter int  N_REQ      = DEF_N_REQ,
    parameter int  DATA_W     = DEF_DATA_W,
    parameter int  ACC_W      = DEF_ACC_W,
    parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int ID_W       = id_width(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_W*TAPS-1:0]  req_window,
    input  logic [N_REQ*DATA_W*TAPS-1:0]  req_weight,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ACC_W-1:0]              res_data,
    output logic [ID_W-1:0]               res_id,
    output logic                          busy,
    output logic [15:0]                   res_count
);

    localparam int SLICE_W = TAPS * DATA_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int OCC_W   = PTR_W + 2;

    logic [ID_W-1:0]    ptr;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;
    logic               credit_ok;
    logic [OCC_W-1:0]   occupancy;
    logic [SLICE_W-1:0] sel_window;
    logic [SLICE_W-1:0] sel_weight;

    logic [ID_W-1:0]    tag;
    logic               core_valid;
    logic [ACC_W-1:0]   core_result;

    logic [ACC_W-1:0]   mem_data [FIFO_DEPTH];
    logic [ID_W-1:0]    mem_id   [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic               push;
    logic               pop;
    logic [15:0]        count_q;

    // Round-robin search in two passes.
    // The first pass looks from ptr upward.
    // The second pass wraps to index 0 when nothing at or above ptr is requesting.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_found && req_valid[i] && ID_W'(i) >= ptr) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
    end

    // Credit check.
    // A pop in this cycle frees a slot in the same cycle, so a full FIFO that is draining keeps the core fed.
    always_comb begin
        occupancy   = OCC_W'(fifo_count) + OCC_W'(core_valid) - OCC_W'(pop);
        credit_ok   = occupancy < OCC_W'(FIFO_DEPTH);
        grant_valid = grant_found && credit_ok && !rst;
    end

    // Steer the granted requester's operands to the core and raise its accept.
    always_comb begin
        sel_window = '0;
        sel_weight = '0;
        req_ready  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_found && ID_W'(i) == grant_idx) begin
                sel_window = req_window[i*SLICE_W +: SLICE_W];
                sel_weight = req_weight[i*SLICE_W +: SLICE_W];
            end
            req_ready[i] = grant_valid && (ID_W'(i) == grant_idx);
        end
    end

    // Priority pointer moves just past the winner and holds when idle.
    // The tag travels one cycle behind the issue, alongside the core's result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            tag <= '0;
        end else if (grant_valid) begin
            ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            tag <= grant_idx;
        end
    end

    conv_core #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (~rst),
        .valid_in  (grant_valid),
        .window    (sel_window),
        .weight    (sel_weight),
        .valid_out (core_valid),
        .result    (core_result)
    );

    assign push      = core_valid;
    assign pop       = res_valid && res_ready;

    // Outputs are forced quiet while reset is held.
    // Nothing from before the reset is visible during it.
    assign res_valid = !rst && (fifo_count != '0);
    assign res_data  = rst ? '0 : mem_data[rd_ptr];
    assign res_id    = rst ? '0 : mem_id[rd_ptr];
    assign busy      = !rst && (core_valid || fifo_count != '0);
    assign res_count = rst ? '0 : count_q;

    // FIFO storage.
    // It needs no reset because the pointers and count decide what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= core_result;
            mem_id[wr_ptr]   <= tag;
        end
    end

    // FIFO pointers, occupancy and the completed-result counter.
    // A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            count_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                count_q <= count_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: doc/conv_arbiter.md
CONV_ARBITER -- requirements
Module: conv_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one convolution core.
REQ-002 Parameter DATA_W, default 8: signed pixel/weight width.
REQ-003 Parameter ACC_W, default 32: signed accumulator/result width.
REQ-004 Parameter FIFO_DEPTH, default 4: result buffer entries, power of two, at least 2.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  N_REQ  per-requester request valid.
REQ-008 req_window  in  N_REQ*DATA_W*9  per-requester 3x3 window; requester i occupies slice i.
REQ-009 req_weight  in  N_REQ*DATA_W*9  per-requester 3x3 kernel, same slicing.
REQ-010 req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-011 res_valid  out  1  result available at FIFO head.
REQ-012 res_ready  in  1  downstream accepts result.
REQ-013 res_data  out  ACC_W  signed convolution sum.
REQ-014 res_id  out  clog2(N_REQ)  requester index of res_data.
REQ-015 busy  out  1  high while any operation is in flight or buffered.
REQ-016 res_count  out  16  completed-result counter, wraps 0xFFFF->0.

Function
REQ-017 Transfer on req_valid[i]&&req_ready[i]; requester SHALL hold valid and data stable until accepted.
REQ-018 Round-robin grant: priority starts at pointer ptr, ascending modulo N_REQ; after grant to i, ptr = (i+1) mod N_REQ; ptr unchanged when nothing is granted.
REQ-019 Issue permitted only when fifo_count + inflight < FIFO_DEPTH (credit rule); then req_ready is asserted combinationally for the granted requester.
REQ-020 Issued window/weight drive the core's valid_in; the granted index is registered alongside as tag.
REQ-021 Core latency exactly 1 cycle: result and tag are pushed into the FIFO on the cycle after issue.
REQ-022 One issue per cycle maximum; back-to-back issues every cycle are sustained while credits allow.
REQ-023 Results SHALL leave in issue order.
REQ-024 res_valid = FIFO not empty; res_data/res_id = head entry; pop on res_valid&&res_ready.
REQ-025 Simultaneous push and pop: count unchanged, both take effect; with FIFO full, pop in a cycle frees credit for issue in the same cycle.
REQ-026 Overflow is impossible by REQ-019; underflow is impossible because pop requires res_valid.
REQ-027 Pointer wrap: FIFO read/write pointers wrap modulo FIFO_DEPTH.
REQ-028 res_count increments by 1 on each pop.
REQ-029 busy = inflight || fifo_count != 0.
REQ-030 Arithmetic: each result is the signed sum of nine DATA_W x DATA_W signed products, sign-extended to ACC_W.

Reset
REQ-031 While rst is high: req_ready=0, res_valid=0, res_data=0, res_id=0, busy=0, res_count=0, ptr=0, FIFO empty, inflight cleared.
REQ-032 Reset asserted mid-operation discards in-flight and buffered results; no result from before reset appears afterward.
REQ-033 First issue possible in the first cycle after rst deasserts.

Structure
REQ-034 Shared package holds default DATA_W, ACC_W, N_REQ, FIFO_DEPTH and the derived ID width constant.
REQ-035 Exactly one sub-module: conv_core instance. Its reset is active-low; drive it with ~rst. Arbiter, tag register and result FIFO are local.

Verification
REQ-036 Requester 0 only, window all 1, weight all 1 -> res_valid 2 cycles after accept, res_data=9, res_id=0.
REQ-037 Requester 2, window all 2, weight all -1 -> res_data=-18 (0xFFFFFFEE), res_id=2.
REQ-038 All four req_valid held, res_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles; res_id follows the same order.
REQ-039 res_ready=0, all requesters valid -> exactly 4 accepts, then req_ready=0; raise res_ready -> 4 results drain in issue order, issuing resumes in the same cycle as the first pop.
REQ-040 rst asserted with 3 results buffered -> next cycle res_valid=0, busy=0, res_count=0; after release, a grant from requester 0 is the first result.
REQ-041 0x10000 completed results -> res_count wraps to 0.
